// File: rtl/hist_win_ctrl.sv
// hist_win_ctrl: runs an external dp_mem as a circular sample history
// and replays the newest win_len samples oldest-first as a valid/last stream.
//
// Ports:
//   clk, aclr            clock, async active-low reset
//   sample_in/_valid     incoming sample, written at the head every valid cycle
//   win_req, win_len     replay request (sampled in IDLE) and window length
//   win_busy, win_err    replay in progress / one-cycle reject pulse
//   win_data/_valid/_last replay stream (win_data is mem_data_out)
//   win_sum/_valid       signed window total (HIST_WIN_SUM_EN), else 0
//   mem_*                dp_mem write port, read port and read data
//
// Optional feature macro: HIST_WIN_SUM_EN (window accumulator).
module hist_win_ctrl #(
    parameter int MEM_DEPTH      = 16,
    parameter int LOG2_MEM_DEPTH = 4,
    parameter int DATA_WIDTH     = 16
) (
    input  logic                                 clk,
    input  logic                                 aclr,
    input  logic [DATA_WIDTH-1:0]                sample_in,
    input  logic                                 sample_valid,
    input  logic                                 win_req,
    input  logic [LOG2_MEM_DEPTH-1:0]            win_len,
    output logic                                 win_busy,
    output logic                                 win_err,
    output logic [DATA_WIDTH-1:0]                win_data,
    output logic                                 win_valid,
    output logic                                 win_last,
    output logic [DATA_WIDTH+LOG2_MEM_DEPTH-1:0] win_sum,
    output logic                                 win_sum_valid,
    output logic                                 mem_w_en,
    output logic [LOG2_MEM_DEPTH-1:0]            mem_w_addr,
    output logic [DATA_WIDTH-1:0]                mem_data_in,
    output logic                                 mem_r_en,
    output logic [LOG2_MEM_DEPTH-1:0]            mem_r_addr,
    input  logic [DATA_WIDTH-1:0]                mem_data_out
);

    localparam int AW = LOG2_MEM_DEPTH;
    localparam int FW = LOG2_MEM_DEPTH + 1;
    localparam int SW = DATA_WIDTH + LOG2_MEM_DEPTH;

    localparam logic [AW-1:0] LAST_ADDR = AW'(MEM_DEPTH - 1);
    localparam logic [FW-1:0] DEPTH_F   = FW'(MEM_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   wptr_q, wptr_d;
    logic [FW-1:0]   fill_q, fill_d;
    logic [AW-1:0]   raddr_q, raddr_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic            valid_q, last_q, err_q;

    logic            req_idle, len_ok, accept, reject;
    logic            read_last;
    logic [FW-1:0]   len_f, wptr_f;
    logic [AW-1:0]   start_addr;

    // Write path: pass-through, held off while reset is asserted.
    assign mem_w_en    = sample_valid & aclr;
    assign mem_w_addr  = wptr_q;
    assign mem_data_in = sample_in;

    assign win_data  = mem_data_out;
    assign win_valid = valid_q;
    assign win_last  = last_q;
    assign win_err   = err_q;

    // Request qualification uses pre-write wptr/fill, so a sample written
    // in the accept cycle is not part of the window.
    assign len_f    = {1'b0, win_len};
    assign wptr_f   = {1'b0, wptr_q};
    assign req_idle = (state_q == IDLE) && win_req;
    assign len_ok   = (win_len != '0) && (len_f <= DEPTH_F - 1'b1)
                      && (len_f <= fill_q);
    assign accept   = req_idle && len_ok;
    assign reject   = req_idle && !len_ok;

    // (wptr - win_len) mod MEM_DEPTH without relying on power-of-2 wrap.
    always_comb begin
        if (wptr_f >= len_f) begin
            start_addr = AW'(wptr_f - len_f);
        end else begin
            start_addr = AW'(wptr_f + DEPTH_F - len_f);
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = READ;
            READ:    if (cnt_q == AW'(1)) state_d = DRAIN;
            DRAIN:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        win_busy   = (state_q != IDLE);
        mem_r_en   = (state_q == READ);
        mem_r_addr = raddr_q;
        read_last  = (state_q == READ) && (cnt_q == AW'(1));
    end

    // Pointer / counter next state
    always_comb begin
        wptr_d  = wptr_q;
        fill_d  = fill_q;
        raddr_d = raddr_q;
        cnt_d   = cnt_q;
        if (sample_valid) begin
            wptr_d = (wptr_q == LAST_ADDR) ? '0 : wptr_q + 1'b1;
            if (fill_q != DEPTH_F) begin
                fill_d = fill_q + 1'b1;
            end
        end
        if (accept) begin
            raddr_d = start_addr;
            cnt_d   = win_len;
        end else if (state_q == READ) begin
            raddr_d = (raddr_q == LAST_ADDR) ? '0 : raddr_q + 1'b1;
            cnt_d   = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            wptr_q  <= '0;
            fill_q  <= '0;
            raddr_q <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            fill_q  <= fill_d;
            raddr_q <= raddr_d;
            cnt_q   <= cnt_d;
            valid_q <= mem_r_en;
            last_q  <= read_last;
            err_q   <= reject;
        end
    end

`ifdef HIST_WIN_SUM_EN
    logic signed [SW-1:0] acc_q, acc_d;
    logic signed [SW-1:0] sum_q, sum_d;
    logic                 sum_vld_q;
    logic signed [SW-1:0] data_ext;

    assign data_ext = {{AW{mem_data_out[DATA_WIDTH-1]}}, mem_data_out};

    always_comb begin
        acc_d = acc_q;
        sum_d = sum_q;
        if (accept) begin
            acc_d = '0;
        end else if (valid_q) begin
            acc_d = acc_q + data_ext;
        end
        // Total includes the last sample, which is on win_data right now.
        if (last_q) begin
            sum_d = acc_q + data_ext;
        end
    end

    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            acc_q     <= '0;
            sum_q     <= '0;
            sum_vld_q <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            sum_q     <= sum_d;
            sum_vld_q <= last_q;
        end
    end

    assign win_sum       = sum_q;
    assign win_sum_valid = sum_vld_q;
`else
    assign win_sum       = '0;
    assign win_sum_valid = 1'b0;
`endif

endmodule

// File: tb/tb_hist_win_ctrl.sv
// tb_hist_win_ctrl: directed + randomized bench for hist_win_ctrl with a
// dp_mem model and a queue-based history reference model.
module tb_hist_win_ctrl;

    logic        clk = 1'b0;
    logic        aclr;
    logic [15:0] sample_in;
    logic        sample_valid;
    logic        win_req;
    logic [3:0]  win_len;
    logic        win_busy, win_err, win_valid, win_last;
    logic [15:0] win_data;
    logic [19:0] win_sum;
    logic        win_sum_valid;
    logic        mem_w_en, mem_r_en;
    logic [3:0]  mem_w_addr, mem_r_addr;
    logic [15:0] mem_data_in, mem_data_out;

`ifdef HIST_WIN_SUM_EN
    localparam bit SUM_EN = 1'b1;
`else
    localparam bit SUM_EN = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    logic [15:0] hist[$];
    int          nwr = 0;
    logic [19:0] sum_reg = '0;

    always #5 clk = ~clk;

    hist_win_ctrl dut (
        .clk           (clk),
        .aclr          (aclr),
        .sample_in     (sample_in),
        .sample_valid  (sample_valid),
        .win_req       (win_req),
        .win_len       (win_len),
        .win_busy      (win_busy),
        .win_err       (win_err),
        .win_data      (win_data),
        .win_valid     (win_valid),
        .win_last      (win_last),
        .win_sum       (win_sum),
        .win_sum_valid (win_sum_valid),
        .mem_w_en      (mem_w_en),
        .mem_w_addr    (mem_w_addr),
        .mem_data_in   (mem_data_in),
        .mem_r_en      (mem_r_en),
        .mem_r_addr    (mem_r_addr),
        .mem_data_out  (mem_data_out)
    );

    logic [15:0] mem [16];
    logic [15:0] mem_rd;
    assign mem_data_out = mem_rd;

    always @(posedge clk) begin
        if (mem_w_en) mem[mem_w_addr] <= mem_data_in;
        if (mem_r_en) mem_rd <= mem[mem_r_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        hist.delete();
        nwr = 0;
        sum_reg = '0;
    endtask

    // Drive inputs at a negedge, let one rising edge pass, land on the next negedge.
    task automatic tick(input bit sv, input logic [15:0] d,
                        input bit rq, input logic [3:0] ln);
        sample_valid = sv;
        sample_in    = d;
        win_req      = rq;
        win_len      = ln;
        @(posedge clk);
        if (sv && aclr) begin
            hist.push_back(d);
            nwr++;
        end
        @(negedge clk);
    endtask

    task automatic wr(input logic [15:0] d);
        tick(1'b1, d, 1'b0, 4'd0);
    endtask

    function automatic bit pick_sv(input int mode);
        if (mode == 0) return 1'b0;
        if (mode == 2) return 1'b1;
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic chk_reset_outs(input string where);
        chk({where, "_busy"}, win_busy, 0);
        chk({where, "_valid"}, win_valid, 0);
        chk({where, "_last"}, win_last, 0);
        chk({where, "_err"}, win_err, 0);
        chk({where, "_r_en"}, mem_r_en, 0);
        chk({where, "_r_addr"}, mem_r_addr, 0);
        chk({where, "_w_en"}, mem_w_en, 0);
        chk({where, "_w_addr"}, mem_w_addr, 0);
        chk({where, "_sum"}, win_sum, 0);
        chk({where, "_sumv"}, win_sum_valid, 0);
    endtask

    task automatic do_reset();
        aclr = 1'b0;
        sample_valid = 1'b1;
        win_req = 1'b1;
        win_len = 4'd1;
        #1;
        chk_reset_outs("rst");
        model_clear();
        @(negedge clk);
        @(negedge clk);
        aclr = 1'b1;
        sample_valid = 1'b0;
        win_req = 1'b0;
    endtask

    // Issue one request and check every cycle until the window has
    // fully drained. abort_at >= 0 pulls reset at that cycle instead.
    task automatic window(input logic [3:0] len, input int mode,
                          input int abort_at);
        int          n, fill, wp0, last_k;
        bit          ok, rq;
        logic [15:0] exp[$];
        logic [19:0] sum;
        n = int'(len);
        fill = (hist.size() > 16) ? 16 : hist.size();
        ok = (n >= 1) && (n <= 15) && (n <= fill);
        sum = '0;
        if (ok) begin
            for (int i = hist.size() - n; i < hist.size(); i++) begin
                exp.push_back(hist[i]);
                sum = sum + {{4{hist[i][15]}}, hist[i]};
            end
        end
        wp0 = nwr % 16;
        last_k = ok ? n + 1 : 1;
        tick(pick_sv(mode), 16'($urandom), 1'b1, len);
        for (int k = 0; k <= last_k; k++) begin
            if (k == abort_at) begin
                aclr = 1'b0;
                #1;
                chk_reset_outs("abort");
                model_clear();
                return;
            end
            chk("busy", win_busy, ok && k <= n);
            chk("valid", win_valid, ok && k >= 1 && k <= n);
            if (ok && k >= 1 && k <= n) chk("data", win_data, exp[k-1]);
            chk("last", win_last, ok && k == n);
            chk("err", win_err, !ok && k == 0);
            chk("r_en", mem_r_en, ok && k < n);
            if (ok && k < n) chk("r_addr", mem_r_addr, (wp0 - n + k + 16) % 16);
            chk("w_en", mem_w_en, sample_valid);
            chk("w_addr", mem_w_addr, nwr % 16);
            chk("sumv", win_sum_valid, SUM_EN && ok && k == n + 1);
            if (SUM_EN && ok && k == n + 1) sum_reg = sum;
            chk("sum", win_sum, sum_reg);
            if (k < last_k) begin
                rq = ok && k <= n && ($urandom_range(0, 1) == 1);
                tick(pick_sv(mode), 16'($urandom), rq, len);
            end
        end
    endtask

    initial begin
        sample_in = '0;
        sample_valid = 1'b0;
        win_req = 1'b0;
        win_len = '0;
        do_reset();
        @(negedge clk);

        for (int i = 1; i <= 5; i++) wr(16'(i));
        window(4'd3, 0, -1);

        for (int i = 1; i <= 20; i++) wr(16'(i));
        window(4'd15, 0, -1);

        window(4'd15, 2, -1);
        window(4'd15, 1, -1);

        wr(16'hFFFD);
        wr(16'h0007);
        wr(16'hFFFF);
        window(4'd3, 0, -1);
        if (SUM_EN) chk("sum_m3_7_m1", win_sum, 20'h3);

        for (int r = 0; r < 25; r++) begin
            int nw;
            nw = $urandom_range(0, 6);
            for (int j = 0; j < nw; j++) wr(16'($urandom));
            window(4'($urandom_range(0, 15)), $urandom_range(0, 2), -1);
        end

        window(4'd10, 1, 4);
        @(negedge clk);
        aclr = 1'b1;
        window(4'd1, 0, -1);

        do_reset();
        @(negedge clk);
        wr(16'h1111);
        wr(16'h2222);
        window(4'd3, 0, -1);
        window(4'd0, 0, -1);
        window(4'd2, 1, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
